// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Purpose: bundles the control and datapath signals that run between the
// fetch sequencer, the test harness (start/done) and the ROM/ALU/data-memory
// datapath.
//
// Signals:
//   start      launch request (harness -> sequencer)
//   prog_sel   program select 0..2, 3 is illegal (harness -> sequencer)
//   inst       ROM word addressed by iptr (ROM -> sequencer)
//   flag_eq/lt/gt  ALU compare result for the current instruction
//   mem_ready  data memory finishes the current ld/st this cycle
//   iptr       registered instruction pointer (sequencer -> ROM)
//   mem_req    ld/st currently executing
//   busy       sequencer is running a program
//   done       sequencer has halted
//   bad_sel    one-cycle pulse after a start with prog_sel = 3
//   retired    retired-instruction count (zero when the counter is not built)
//
// Modports:
//   master  the sequencer itself (drives iptr and the status outputs)
//   slave   the surrounding harness/datapath
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
  logic        start;
  logic [1:0]  prog_sel;
  logic [19:0] inst;
  logic        flag_eq;
  logic        flag_lt;
  logic        flag_gt;
  logic        mem_ready;
  logic [8:0]  iptr;
  logic        mem_req;
  logic        busy;
  logic        done;
  logic        bad_sel;
  logic [15:0] retired;

  modport master (
    input  start, prog_sel, inst, flag_eq, flag_lt, flag_gt, mem_ready,
    output iptr, mem_req, busy, done, bad_sel, retired
  );

  modport slave (
    output start, prog_sel, inst, flag_eq, flag_lt, flag_gt, mem_ready,
    input  iptr, mem_req, busy, done, bad_sel, retired
  );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose: program counter and fetch controller for the 20-bit single-issue
// core. Launches one of three resident programs, resolves relative branches
// against the flags latched by the most recent cmp, stalls on data-memory
// handshakes and halts on the done opcode (or any illegal opcode).
//
// Ports:
//   clk    single rising-edge clock
//   reset  synchronous, active-high
//   bus    fetch_sequencer_if.master (see interface file for signal list)
//
// Build option:
//   FETCH_SEQ_CNT_EN  when defined, a saturating 16-bit retired-instruction
//                     counter drives bus.retired; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module fetch_sequencer (
  input  logic                      clk,
  input  logic                      reset,
  fetch_sequencer_if.master         bus
);

  localparam logic [8:0] PROD_BASE = 9'h001;
  localparam logic [8:0] STR_BASE  = 9'h019;
  localparam logic [8:0] PAIR_BASE = 9'h02A;

  localparam logic [4:0] OP_CMP  = 5'd6;
  localparam logic [4:0] OP_BE   = 5'd7;
  localparam logic [4:0] OP_BL   = 5'd8;
  localparam logic [4:0] OP_BG   = 5'd9;
  localparam logic [4:0] OP_BA   = 5'd10;
  localparam logic [4:0] OP_LD   = 5'd12;
  localparam logic [4:0] OP_ST   = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  iptr_q, iptr_d;
  logic [2:0]  flags_q, flags_d;   // {eq, lt, gt} from the last cmp
  logic        bad_sel_q, bad_sel_d;
  logic        mem_req_c;

  logic [4:0]  opcode;
  logic [8:0]  offset9;
  logic [8:0]  iptr_inc;
  logic [8:0]  iptr_tgt;
  logic        is_mem;
  logic        sel_ok;

  // Only the low nine offset bits matter: address space is 512 words and
  // arithmetic wraps, so the upper offset bits are deliberately ignored.
  logic        unused_inst_bits;
  assign unused_inst_bits = ^bus.inst[14:9];

  assign opcode   = bus.inst[19:15];
  assign offset9  = bus.inst[8:0];
  assign iptr_inc = iptr_q + 9'd1;
  assign iptr_tgt = iptr_q + offset9;
  assign is_mem   = (opcode == OP_LD) || (opcode == OP_ST);
  assign sel_ok   = (bus.prog_sel != 2'd3);

  always_comb begin
    state_d   = state_q;
    iptr_d    = iptr_q;
    flags_d   = flags_q;
    bad_sel_d = 1'b0;
    mem_req_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          if (sel_ok) begin
            state_d = ST_RUN;
            flags_d = 3'b000;
            case (bus.prog_sel)
              2'd0:    iptr_d = PROD_BASE;
              2'd1:    iptr_d = STR_BASE;
              default: iptr_d = PAIR_BASE;
            endcase
          end else begin
            bad_sel_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        case (opcode)
          OP_CMP: begin
            flags_d = {bus.flag_eq, bus.flag_lt, bus.flag_gt};
            iptr_d  = iptr_inc;
          end
          OP_BE:   iptr_d = flags_q[2] ? iptr_tgt : iptr_inc;
          OP_BL:   iptr_d = flags_q[1] ? iptr_tgt : iptr_inc;
          OP_BG:   iptr_d = flags_q[0] ? iptr_tgt : iptr_inc;
          OP_BA:   iptr_d = iptr_tgt;
          OP_LD, OP_ST: begin
            mem_req_c = 1'b1;
            if (bus.mem_ready) begin
              iptr_d = iptr_inc;
            end
          end
          5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11: iptr_d = iptr_inc;
          // 14 (done) and every opcode from 15 up stop the program with
          // iptr left pointing at the halting instruction.
          default: state_d = ST_HALT;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      iptr_q    <= 9'd0;
      flags_q   <= 3'b000;
      bad_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iptr_q    <= iptr_d;
      flags_q   <= flags_d;
      bad_sel_q <= bad_sel_d;
    end
  end

  assign bus.iptr    = iptr_q;
  assign bus.mem_req = mem_req_c;
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_HALT);
  assign bus.bad_sel = bad_sel_q;

`ifdef FETCH_SEQ_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic        retire;
  logic        launch;

  // Every RUN cycle retires an instruction except a ld/st still waiting on
  // memory; the halting instruction counts too.
  assign retire = (state_q == ST_RUN) && !(is_mem && !bus.mem_ready);
  assign launch = (state_q != ST_RUN) && bus.start && sel_ok;

  always_comb begin
    retired_d = retired_q;
    if (launch) begin
      retired_d = 16'd0;
    end else if (retire && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 16'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.retired = retired_q;
`else
  logic unused_is_mem;
  assign unused_is_mem = is_mem;
  assign bus.retired   = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  fetch_sequencer_if bus ();

  logic [19:0] rom [0:511];
  assign bus.inst = rom[bus.iptr];

  fetch_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0]  iptr;
    logic        busy;
    logic        done;
    logic        bad_sel;
    logic        mem_req;
    logic [15:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Reference model state: a program is either running, halted or idle.
  bit         m_run;
  bit         m_halt;
  logic [8:0] m_pc;
  bit         m_eq, m_lt, m_gt;
  int         m_cnt;
  bit         m_bad;

  function automatic logic [8:0] base_of(input logic [1:0] s);
    if (s == 2'd0) return 9'h001;
    if (s == 2'd1) return 9'h019;
    return 9'h02A;
  endfunction

  function automatic int op_at(input logic [8:0] a);
    logic [19:0] w;
    w = rom[a];
    return int'(w[19:15]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, req);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the
  // outputs expected just after the coming rising edge.
  task automatic step(input bit r, input bit st, input logic [1:0] sel,
                      input bit eq, input bit lt, input bit gt, input bit rdy);
    int         op;
    logic [19:0] w;
    logic [8:0] tgt;
    bit         stalled;
    bit         taken;
    exp_t       e;
    @(negedge clk);
    reset         = r;
    bus.start     = st;
    bus.prog_sel  = sel;
    bus.flag_eq   = eq;
    bus.flag_lt   = lt;
    bus.flag_gt   = gt;
    bus.mem_ready = rdy;

    if (r) begin
      m_run = 0; m_halt = 0; m_pc = 9'd0;
      m_eq = 0; m_lt = 0; m_gt = 0; m_cnt = 0; m_bad = 0;
    end else if (!m_run) begin
      m_bad = 0;
      if (st) begin
        if (sel == 2'd3) begin
          m_bad = 1;
        end else begin
          m_pc = base_of(sel);
          m_eq = 0; m_lt = 0; m_gt = 0;
          m_cnt = 0; m_run = 1; m_halt = 0;
        end
      end
    end else begin
      m_bad   = 0;
      w       = rom[m_pc];
      op      = int'(w[19:15]);
      tgt     = m_pc + w[8:0];
      stalled = 0;
      if (op == 6) begin
        m_eq = eq; m_lt = lt; m_gt = gt;
        m_pc = m_pc + 9'd1;
      end else if (op >= 7 && op <= 10) begin
        taken = (op == 10) || (op == 7 && m_eq) || (op == 8 && m_lt) || (op == 9 && m_gt);
        m_pc  = taken ? tgt : m_pc + 9'd1;
      end else if (op == 12 || op == 13) begin
        if (rdy) m_pc = m_pc + 9'd1;
        else stalled = 1;
      end else if (op >= 14) begin
        m_run = 0; m_halt = 1;
      end else begin
        m_pc = m_pc + 9'd1;
      end
      if (!stalled && m_cnt < 65535) m_cnt++;
    end

    e.iptr    = m_pc;
    e.busy    = m_run;
    e.done    = m_halt;
    e.bad_sel = m_bad;
    e.mem_req = m_run && (op_at(m_pc) == 12 || op_at(m_pc) == 13);
`ifdef FETCH_SEQ_CNT_EN
    e.retired = 16'(m_cnt);
`else
    e.retired = 16'd0;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d iptr=%03h busy=%0b done=%0b bad_sel=%0b mem_req=%0b retired=%0d",
                 txn, bus.iptr, bus.busy, bus.done, bus.bad_sel, bus.mem_req, bus.retired);
        chk("iptr",    32'(bus.iptr),    32'(e.iptr));
        chk("busy",    32'(bus.busy),    32'(e.busy));
        chk("done",    32'(bus.done),    32'(e.done));
        chk("bad_sel", 32'(bus.bad_sel), 32'(e.bad_sel));
        chk("mem_req", 32'(bus.mem_req), 32'(e.mem_req));
        chk("retired", 32'(bus.retired), 32'(e.retired));
      end
    end
  end

  function automatic logic [19:0] rand_inst();
    int k;
    logic [4:0]  op;
    logic [14:0] low;
    k   = $urandom_range(0, 99);
    low = 15'($urandom);
    if (k < 40) begin
      k  = $urandom_range(0, 6);
      op = (k == 6) ? 5'd11 : 5'(k);
    end else if (k < 55) op = 5'd6;
    else if (k < 70) op = 5'($urandom_range(7, 10));
    else if (k < 82) op = 5'($urandom_range(12, 13));
    else if (k < 90) op = 5'd14;
    else if (k < 93) op = 5'($urandom_range(15, 31));
    else op = 5'd0;
    return {op, low};
  endfunction

  initial begin
    int ncmp;
    reset = 1'b1; bus.start = 0; bus.prog_sel = 0;
    bus.flag_eq = 0; bus.flag_lt = 0; bus.flag_gt = 0; bus.mem_ready = 0;

    // Directed program image.
    for (int i = 0; i < 512; i++) rom[i] = 20'd0;
    rom[9'h001] = {5'd12, 15'd0};     // ld
    rom[9'h00F] = {5'd6,  15'd0};     // cmp
    rom[9'h010] = {5'd8,  15'h7FF2};  // bl -14 -> 0x002
    rom[9'h011] = {5'd14, 15'd0};     // done
    rom[9'h019] = {5'd14, 15'd0};     // done
    rom[9'h03B] = {5'd14, 15'd0};     // done

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);        // illegal select in IDLE
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);        // program 1
    step(0, 0, 0, 0, 0, 0, 0);        // done at 0x019
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);        // program 0 from HALT
    step(0, 0, 0, 0, 0, 0, 0);        // ld stalls three cycles
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    ncmp = 0;
    for (int k = 0; k < 100 && m_run; k++) begin
      bit lt;
      lt = (ncmp == 0);
      if (op_at(m_pc) == 6) ncmp++;
      step(0, 1, 2'(k), 0, lt, 0, 1); // start while running is ignored
    end
    step(0, 1, 2, 0, 0, 0, 1);        // program 2
    for (int k = 0; k < 100 && m_run; k++) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);        // program 0 again, stall then reset
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized program image and stimulus.
    for (int i = 0; i < 512; i++) rom[i] = rand_inst();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
